// File: rtl/io_port_resp_if.sv
`default_nettype none
// ============================================================================
//  Module      : io_port_resp_if
//  Description : Bundles the core-side port access signals, the external
//                producer write port and the external consumer FIFO head port
//                of io_port_resp into one interface.
//  Revision    : 1.0  initial release
// ============================================================================
interface io_port_resp_if #(
    parameter int NBMANT = 16,
    parameter int NBEXPO = 6,
    parameter int NUIOIN = 8,
    parameter int NUIOOU = 8
);
    localparam int W  = NBMANT + NBEXPO + 1;
    localparam int AI = (NUIOIN > 1) ? $clog2(NUIOIN) : 1;
    localparam int AO = (NUIOOU > 1) ? $clog2(NUIOOU) : 1;

    // core read side
    logic              req_in;
    logic [AI-1:0]     addr_in;
    logic [W-1:0]      io_in;
    // core write side
    logic              out_en;
    logic [AO-1:0]     addr_out;
    logic [W-1:0]      data_out;
    // external producer
    logic              ext_in_we;
    logic [AI-1:0]     ext_in_addr;
    logic [W-1:0]      ext_in_data;
    logic [NUIOIN-1:0] ext_in_full;
    // external consumer
    logic              ext_out_valid;
    logic              ext_out_ready;
    logic [AO-1:0]     ext_out_addr;
    logic [W-1:0]      ext_out_data;
    // status
    logic              fifo_full;
    logic              ovf_err;

    // Core plus external agents drive the block from this side.
    modport master (
        output req_in, addr_in, out_en, addr_out, data_out,
               ext_in_we, ext_in_addr, ext_in_data, ext_out_ready,
        input  io_in, ext_in_full, ext_out_valid, ext_out_addr,
               ext_out_data, fifo_full, ovf_err
    );

    // The port block itself.
    modport slave (
        input  req_in, addr_in, out_en, addr_out, data_out,
               ext_in_we, ext_in_addr, ext_in_data, ext_out_ready,
        output io_in, ext_in_full, ext_out_valid, ext_out_addr,
               ext_out_data, fifo_full, ovf_err
    );
endinterface
`default_nettype wire

// File: rtl/io_port_resp.sv
`default_nettype none
// ============================================================================
//  Module      : io_port_resp
//  Description : Core I/O port responder. Input side is a bank of mailbox
//                registers with valid flags written by an external producer
//                and read combinationally by the core. Output side is a
//                first-word-fall-through FIFO of {port, data} entries drained
//                by an external consumer, with a sticky overflow flag.
//  Revision    : 1.0  initial release
// ============================================================================
module io_port_resp #(
    parameter int NBMANT = 16,
    parameter int NBEXPO = 6,
    parameter int NUIOIN = 8,
    parameter int NUIOOU = 8,
    parameter int FDEPTH = 4
) (
    input  wire logic      clk,
    input  wire logic      rst,     // asynchronous, active low
    io_port_resp_if.slave  bus
);
    localparam int W  = NBMANT + NBEXPO + 1;
    localparam int AI = (NUIOIN > 1) ? $clog2(NUIOIN) : 1;
    localparam int AO = (NUIOOU > 1) ? $clog2(NUIOOU) : 1;
    localparam int PW = (FDEPTH > 1) ? $clog2(FDEPTH) : 1;

    localparam logic [PW:0] c_DEPTH = (PW+1)'(FDEPTH);
    localparam logic [PW:0] c_EMPTY = '0;

    // ------------------------------------------------------------------
    // Input mailbox registers
    // ------------------------------------------------------------------
    logic [W-1:0]      r_in_data [NUIOIN];
    logic [NUIOIN-1:0] r_in_valid;

    // Producer writes set the valid flag; core reads clear it. The write
    // is applied last so a same-edge write to the port being read wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUIOIN; i++) begin
                r_in_data[i] <= '0;
            end
            r_in_valid <= '0;
        end else begin
            if (bus.req_in) begin
                r_in_valid[bus.addr_in] <= 1'b0;
            end
            if (bus.ext_in_we) begin
                r_in_data[bus.ext_in_addr]  <= bus.ext_in_data;
                r_in_valid[bus.ext_in_addr] <= 1'b1;
            end
        end
    end

    // Zero-latency read path: the core sees the stored value regardless of
    // strobe or valid state.
    assign bus.io_in       = r_in_data[bus.addr_in];
    assign bus.ext_in_full = r_in_valid;

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    logic [AO-1:0] r_fifo_addr [FDEPTH];
    logic [W-1:0]  r_fifo_data [FDEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [PW:0]   r_count;
    logic          r_ovf_err;

    logic w_full;
    logic w_valid;
    logic w_pop;
    logic w_push;

    assign w_full  = (r_count == c_DEPTH);
    assign w_valid = (r_count != c_EMPTY);
    assign w_pop   = w_valid && bus.ext_out_ready;
    // A full FIFO still accepts a write when the head leaves on the same edge.
    assign w_push  = bus.out_en && (!w_full || w_pop);

    // FIFO storage, pointers and occupancy; pointers wrap naturally since
    // the depth is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FDEPTH; i++) begin
                r_fifo_addr[i] <= '0;
                r_fifo_data[i] <= '0;
            end
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_fifo_addr[r_wr_ptr] <= bus.addr_out;
                r_fifo_data[r_wr_ptr] <= bus.data_out;
                r_wr_ptr              <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overflow: a core write arriving while full with no pop is lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ovf_err <= 1'b0;
        end else if (bus.out_en && w_full && !w_pop) begin
            r_ovf_err <= 1'b1;
        end
    end

    // First-word fall-through head presentation.
    assign bus.ext_out_valid = w_valid;
    assign bus.ext_out_addr  = r_fifo_addr[r_rd_ptr];
    assign bus.ext_out_data  = r_fifo_data[r_rd_ptr];
    assign bus.fifo_full     = w_full;
    assign bus.ovf_err       = r_ovf_err;

endmodule
`default_nettype wire

// File: tb/tb_io_port_resp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_io_port_resp
//  Description : Directed self-checking bench for io_port_resp.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_io_port_resp;
    localparam int NBMANT = 16;
    localparam int NBEXPO = 6;
    localparam int NUIOIN = 8;
    localparam int NUIOOU = 8;
    localparam int FDEPTH = 4;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    io_port_resp_if #(
        .NBMANT(NBMANT), .NBEXPO(NBEXPO), .NUIOIN(NUIOIN), .NUIOOU(NUIOOU)
    ) bus ();

    io_port_resp #(
        .NBMANT(NBMANT), .NBEXPO(NBEXPO), .NUIOIN(NUIOIN),
        .NUIOOU(NUIOOU), .FDEPTH(FDEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // advance one rising edge, then settle away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b0;
        bus.req_in = 1'b0;        bus.addr_in = '0;
        bus.out_en = 1'b0;        bus.addr_out = '0;     bus.data_out = '0;
        bus.ext_in_we = 1'b0;     bus.ext_in_addr = '0;  bus.ext_in_data = '0;
        bus.ext_out_ready = 1'b0;

        // ---------------- reset state ----------------
        tick();
        check("rst_io_in",     32'(bus.io_in), 32'h0);
        check("rst_in_full",   32'(bus.ext_in_full), 32'h0);
        check("rst_out_valid", 32'(bus.ext_out_valid), 32'h0);
        check("rst_out_addr",  32'(bus.ext_out_addr), 32'h0);
        check("rst_out_data",  32'(bus.ext_out_data), 32'h0);
        check("rst_fifo_full", 32'(bus.fifo_full), 32'h0);
        check("rst_ovf",       32'(bus.ovf_err), 32'h0);
        #2 rst = 1'b1;
        tick();

        // ---------------- producer write then core read ----------------
        bus.ext_in_we = 1'b1; bus.ext_in_addr = 3'd3; bus.ext_in_data = 23'h12345;
        tick();
        bus.ext_in_we = 1'b0;
        check("p3_full_set", 32'(bus.ext_in_full), 32'h08);
        bus.addr_in = 3'd3; bus.req_in = 1'b1;
        #1 check("p3_read_data", 32'(bus.io_in), 32'h12345);
        tick();
        bus.req_in = 1'b0;
        check("p3_full_clr", 32'(bus.ext_in_full), 32'h00);
        check("p3_data_kept", 32'(bus.io_in), 32'h12345);

        // ---------------- same-edge write and read ----------------
        bus.ext_in_we = 1'b1; bus.ext_in_addr = 3'd2; bus.ext_in_data = 23'h55;
        tick();
        check("p2_full_old", 32'(bus.ext_in_full), 32'h04);
        bus.ext_in_data = 23'hAA;
        bus.addr_in = 3'd2; bus.req_in = 1'b1;
        #1 check("p2_read_old", 32'(bus.io_in), 32'h55);
        tick();
        bus.ext_in_we = 1'b0; bus.req_in = 1'b0;
        #1 check("p2_new_data", 32'(bus.io_in), 32'hAA);
        check("p2_full_kept", 32'(bus.ext_in_full), 32'h04);

        // reading an unwritten port returns 0, no side effects
        bus.addr_in = 3'd5;
        #1 check("p5_empty_read", 32'(bus.io_in), 32'h0);

        // ---------------- FIFO overflow then drain ----------------
        bus.ext_out_ready = 1'b0;
        bus.out_en = 1'b1; bus.addr_out = 3'd1;
        for (int k = 1; k <= 5; k++) begin
            bus.data_out = 23'(k);
            tick();
            if (k == 4) begin
                check("ovf_full_at4", 32'(bus.fifo_full), 32'h1);
                check("ovf_clear_at4", 32'(bus.ovf_err), 32'h0);
            end
        end
        bus.out_en = 1'b0;
        check("ovf_set", 32'(bus.ovf_err), 32'h1);
        check("ovf_still_full", 32'(bus.fifo_full), 32'h1);
        check("ovf_head_addr", 32'(bus.ext_out_addr), 32'h1);
        bus.ext_out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            #1 check($sformatf("drain_data_%0d", k), 32'(bus.ext_out_data), 32'(k));
            check($sformatf("drain_valid_%0d", k), 32'(bus.ext_out_valid), 32'h1);
            tick();
        end
        bus.ext_out_ready = 1'b0;
        check("drain_empty", 32'(bus.ext_out_valid), 32'h0);
        check("drain_not_full", 32'(bus.fifo_full), 32'h0);
        check("ovf_sticky", 32'(bus.ovf_err), 32'h1);

        // reset clears the sticky flag
        rst = 1'b0;
        #1 check("ovf_rst_clear", 32'(bus.ovf_err), 32'h0);
        #1 rst = 1'b1;
        tick();

        // ---------------- full with simultaneous push and pop ----------------
        bus.out_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.addr_out = 3'(k + 2);
            bus.data_out = 23'(8'h10 + k);
            tick();
        end
        bus.addr_out = 3'd6; bus.data_out = 23'h14; bus.ext_out_ready = 1'b1;
        #1 check("pp_full_before", 32'(bus.fifo_full), 32'h1);
        check("pp_head_before", 32'(bus.ext_out_data), 32'h10);
        tick();
        bus.out_en = 1'b0; bus.ext_out_ready = 1'b0;
        check("pp_full_after", 32'(bus.fifo_full), 32'h1);
        check("pp_no_ovf", 32'(bus.ovf_err), 32'h0);
        bus.ext_out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            #1 check($sformatf("pp_data_%0d", k), 32'(bus.ext_out_data), 32'(8'h10 + k));
            check($sformatf("pp_addr_%0d", k), 32'(bus.ext_out_addr), 32'(k + 2));
            tick();
        end
        check("pp_empty", 32'(bus.ext_out_valid), 32'h0);

        // ---------------- ten push/pop cycles, pointer wrap ----------------
        // ready stays high; first push lands in an empty FIFO (ready ignored),
        // afterwards each edge pops the previous entry and pushes the next.
        bus.out_en = 1'b1; bus.addr_out = 3'd7;
        for (int i = 0; i < 10; i++) begin
            bus.data_out = 23'(12'h100 + i);
            #1;
            if (i == 0) begin
                check("wrap_empty_start", 32'(bus.ext_out_valid), 32'h0);
            end else begin
                check($sformatf("wrap_head_%0d", i), 32'(bus.ext_out_data), 32'(12'h100 + i - 1));
            end
            tick();
        end
        bus.out_en = 1'b0;
        check("wrap_last_head", 32'(bus.ext_out_data), 32'h109);
        check("wrap_last_valid", 32'(bus.ext_out_valid), 32'h1);
        tick();
        bus.ext_out_ready = 1'b0;
        check("wrap_drained", 32'(bus.ext_out_valid), 32'h0);
        check("wrap_no_ovf", 32'(bus.ovf_err), 32'h0);

        // ---------------- async reset mid-operation ----------------
        bus.out_en = 1'b1; bus.addr_out = 3'd4;
        bus.data_out = 23'h2A;
        bus.ext_in_we = 1'b1; bus.ext_in_addr = 3'd1; bus.ext_in_data = 23'h777;
        tick();
        bus.ext_in_we = 1'b0;
        bus.data_out = 23'h2B;
        tick();
        bus.out_en = 1'b0; bus.addr_in = 3'd1;
        #1 check("mid_valid_pre", 32'(bus.ext_out_valid), 32'h1);
        check("mid_io_in_pre", 32'(bus.io_in), 32'h777);
        rst = 1'b0;
        #1;
        check("mid_io_in",     32'(bus.io_in), 32'h0);
        check("mid_in_full",   32'(bus.ext_in_full), 32'h0);
        check("mid_out_valid", 32'(bus.ext_out_valid), 32'h0);
        check("mid_out_addr",  32'(bus.ext_out_addr), 32'h0);
        check("mid_out_data",  32'(bus.ext_out_data), 32'h0);
        check("mid_fifo_full", 32'(bus.fifo_full), 32'h0);
        check("mid_ovf",       32'(bus.ovf_err), 32'h0);
        #1 rst = 1'b1;
        // first edge after release behaves as from empty
        bus.out_en = 1'b1; bus.addr_out = 3'd5; bus.data_out = 23'h3C;
        bus.ext_out_ready = 1'b1;
        tick();
        bus.out_en = 1'b0; bus.ext_out_ready = 1'b0;
        check("post_rst_valid", 32'(bus.ext_out_valid), 32'h1);
        check("post_rst_data",  32'(bus.ext_out_data), 32'h3C);
        check("post_rst_addr",  32'(bus.ext_out_addr), 32'h5);
        tick();
        check("post_rst_hold",  32'(bus.ext_out_data), 32'h3C);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
